algorithm_multi_vc: RTL and testbench

Per-input routing stage for the mesh router with a parametrised number of virtual channels (VCs) per output direction. It computes the Y-first dimension-order output port from the packet's target coordinates and selects a VC on that port. The choice is locked from the header beat through TLAST. It sits between an input buffer and the crossbar arbiters, one instance per router input, and replaces the fixed two-VC router stage.

---
 rtl/algorithm_multi_vc_pkg.sv | 35 +++
 rtl/algorithm_multi_vc_vc_select.sv | 25 ++
 rtl/algorithm_multi_vc.sv | 140 ++++++++++++++
 tb/tb_algorithm_multi_vc.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/algorithm_multi_vc_pkg.sv
// Shared router types: routing-header TID, output port enum, AXI-Stream
// forward/backward structs and the flattened channel-index helper.
// Channel numbering is port*VC_PER_PORT + vc, ports ordered L,N,E,S,W.
package algorithm_multi_vc_pkg;

   localparam int AXIS_DATA_W = 32;
   localparam int AXIS_ID_W   = 4;

   // TID value that marks the first beat of a packet
   localparam logic [AXIS_ID_W-1:0] ROUTING_HEADER = 4'hA;

   typedef enum logic [2:0] {
      PORT_LOCAL = 3'd0,
      PORT_NORTH = 3'd1,
      PORT_EAST  = 3'd2,
      PORT_SOUTH = 3'd3,
      PORT_WEST  = 3'd4
   } port_e;

   typedef struct packed {
      logic                   tvalid;
      logic                   tlast;
      logic [AXIS_ID_W-1:0]   tid;
      logic [AXIS_DATA_W-1:0] tdata;
   } axis_mosi_t;

   typedef struct packed {
      logic tready;
   } axis_miso_t;

   function automatic int chan_index(input port_e port, input int vc, input int vc_per_port);
      return int'(port) * vc_per_port + vc;
   endfunction

endpackage

// File: rtl/algorithm_multi_vc_vc_select.sv
// Lowest-free-VC priority encoder over the busy bits of one output port.
// Purely combinational, zero latency; no flow control of its own.
// Ports: busy_i (per-VC busy), vc_o (lowest free VC), none_free_o (all busy).
module vc_select #(
   parameter int VC_PER_PORT = 2,
   parameter int VC_WIDTH    = 1
) (
   input  logic [VC_PER_PORT-1:0] busy_i,
   output logic [VC_WIDTH-1:0]    vc_o,
   output logic                   none_free_o
);

   // Scan from the top so the lowest free index is the last one written
   always_comb begin
      vc_o        = '0;
      none_free_o = 1'b1;
      for (int i = VC_PER_PORT - 1; i >= 0; i--) begin
         if (!busy_i[i]) begin
            vc_o        = VC_WIDTH'(i);
            none_free_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/algorithm_multi_vc.sv
// Per-input Y-first routing stage: picks output port + VC, locks it header..TLAST.
// Latency: zero-cycle combinational forward/backpressure path; lock/drop registered.
// Backpressure: header stalls while its channel is busy; stray IDLE beats are sunk.
// Ports: clk_i/rst_i (sync, active-high), in_mosi_i/in_miso_o input stream,
//   out_mosi_o/out_miso_i per-channel streams, target_x_i/target_y_i destination,
//   vc_sel_i requested VC, chan_busy_i foreign ownership, chan_lock_o ownership,
//   drop_o stray-beat pulse. Option macro: ADAPTIVE_VC_EN (lowest free VC).
module algorithm_multi_vc
   import algorithm_multi_vc_pkg::*;
#(
   parameter int VC_PER_PORT         = 2,
   parameter int PORT_NUMBER         = 5,
   parameter int CHANNEL_NUMBER      = PORT_NUMBER * VC_PER_PORT,
   parameter int MAX_ROUTERS_X       = 4,
   parameter int MAX_ROUTERS_Y       = 4,
   parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
   parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y),
   parameter int ROUTER_X            = 0,
   parameter int ROUTER_Y            = 0,
   parameter int VC_WIDTH            = (VC_PER_PORT > 1) ? $clog2(VC_PER_PORT) : 1
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  axis_mosi_t                          in_mosi_i,
   output axis_miso_t                          in_miso_o,
   output axis_mosi_t [CHANNEL_NUMBER-1:0]     out_mosi_o,
   input  axis_miso_t [CHANNEL_NUMBER-1:0]     out_miso_i,
   input  logic [MAX_ROUTERS_X_WIDTH-1:0]      target_x_i,
   input  logic [MAX_ROUTERS_Y_WIDTH-1:0]      target_y_i,
   input  logic [VC_WIDTH-1:0]                 vc_sel_i,
   input  logic [CHANNEL_NUMBER-1:0]           chan_busy_i,
   output logic [CHANNEL_NUMBER-1:0]           chan_lock_o,
   output logic                                drop_o
);

   localparam int CH_W = (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1;
   localparam logic [MAX_ROUTERS_X_WIDTH-1:0] RX = MAX_ROUTERS_X_WIDTH'(ROUTER_X);
   localparam logic [MAX_ROUTERS_Y_WIDTH-1:0] RY = MAX_ROUTERS_Y_WIDTH'(ROUTER_Y);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

   state_e                    state_q;
   logic [CH_W-1:0]           ch_q;
   logic                      single_q;   // locked by a header that was also TLAST
   logic                      drop_q;
   logic [CHANNEL_NUMBER-1:0] lock_q;

   port_e                     port_sel;
   logic [VC_WIDTH-1:0]       vc_pick;
   logic [CH_W-1:0]           ch_new;
   logic [CH_W-1:0]           ch_cur;
   logic                      vc_ok;
   logic                      is_header;
   logic                      route_en;
   logic                      hs;

   assign is_header = in_mosi_i.tvalid && (in_mosi_i.tid == ROUTING_HEADER);

   // Y-first dimension-order routing
   always_comb begin
      if (target_x_i == RX && target_y_i == RY) port_sel = PORT_LOCAL;
      else if (target_y_i < RY)                 port_sel = PORT_NORTH;
      else if (target_y_i > RY)                 port_sel = PORT_SOUTH;
      else if (target_x_i > RX)                 port_sel = PORT_EAST;
      else                                      port_sel = PORT_WEST;
   end

   assign ch_new = CH_W'(chan_index(port_sel, int'(vc_pick), VC_PER_PORT));

`ifdef ADAPTIVE_VC_EN
   logic none_free;

   vc_select #(
      .VC_PER_PORT (VC_PER_PORT),
      .VC_WIDTH    (VC_WIDTH)
   ) u_vc_select (
      .busy_i      (chan_busy_i[int'(port_sel)*VC_PER_PORT +: VC_PER_PORT]),
      .vc_o        (vc_pick),
      .none_free_o (none_free)
   );

   assign vc_ok = !none_free;
`else
   assign vc_pick = VC_WIDTH'(int'(vc_sel_i) % VC_PER_PORT);
   assign vc_ok   = !chan_busy_i[ch_new];
`endif

   // Forward path. During the single-beat hold cycle nothing is routed.
   always_comb begin
      out_mosi_o = '0;
      in_miso_o  = '0;
      route_en   = 1'b0;
      ch_cur     = ch_q;
      if (!rst_i) begin
         if (state_q == ST_LOCKED) begin
            route_en = !single_q;
         end else if (is_header) begin
            route_en = vc_ok;
            ch_cur   = ch_new;
         end else if (in_mosi_i.tvalid) begin
            in_miso_o.tready = 1'b1;   // stray beat is sunk
         end
      end
      if (route_en) begin
         out_mosi_o[ch_cur] = in_mosi_i;
         in_miso_o          = out_miso_i[ch_cur];
      end
   end

   assign hs = route_en && in_mosi_i.tvalid && out_miso_i[ch_cur].tready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         ch_q     <= '0;
         single_q <= 1'b0;
         lock_q   <= '0;
         drop_q   <= 1'b0;
      end else begin
         drop_q <= (state_q == ST_IDLE) && in_mosi_i.tvalid && !is_header;
         if (state_q == ST_IDLE) begin
            if (hs) begin
               state_q        <= ST_LOCKED;
               ch_q           <= ch_cur;
               single_q       <= in_mosi_i.tlast;
               lock_q         <= '0;
               lock_q[ch_cur] <= 1'b1;
            end
         end else if (single_q || (hs && in_mosi_i.tlast)) begin
            state_q  <= ST_IDLE;
            single_q <= 1'b0;
            lock_q   <= '0;
         end
      end
   end

   assign chan_lock_o = lock_q;
   assign drop_o      = drop_q;

endmodule

// File: tb/tb_algorithm_multi_vc.sv
module tb_algorithm_multi_vc;
   import algorithm_multi_vc_pkg::*;

   localparam int V  = 3;
   localparam int CH = 5 * V;

   logic clk = 1'b0;
   logic rst;
   axis_mosi_t in_mosi;
   axis_miso_t in_miso;
   axis_mosi_t [CH-1:0] out_mosi;
   axis_miso_t [CH-1:0] out_miso;
   logic [1:0] tx, ty, vs;
   logic [CH-1:0] busy, lock;
   logic drop;

   int total = 0;
   int bad   = 0;

   // reference model state: owned channel (-1 none), single-beat hold, pending drop
   int m_lock = -1;
   bit m_hold = 0;
   bit m_drop = 0;

   always #5 clk = ~clk;

   algorithm_multi_vc #(
      .VC_PER_PORT (V),
      .ROUTER_X    (1),
      .ROUTER_Y    (1)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_mosi_i   (in_mosi),
      .in_miso_o   (in_miso),
      .out_mosi_o  (out_mosi),
      .out_miso_i  (out_miso),
      .target_x_i  (tx),
      .target_y_i  (ty),
      .vc_sel_i    (vs),
      .chan_busy_i (busy),
      .chan_lock_o (lock),
      .drop_o      (drop)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Router at (1,1): Y-first port choice, then VC per build option
   function automatic int route(input int x, input int y, input int vsel, input logic [CH-1:0] b);
      int p;
      if (x == 1 && y == 1) p = 0;
      else if (y < 1)       p = 1;
      else if (y > 1)       p = 3;
      else if (x > 1)       p = 2;
      else                  p = 4;
`ifdef ADAPTIVE_VC_EN
      for (int i = 0; i < V; i++) if (!b[p*V+i]) return p*V + i;
      return -1;
`else
      if (b[p*V + vsel % V]) return -1;
      return p*V + vsel % V;
`endif
   endfunction

   task automatic drv(input bit v, input logic [3:0] id, input bit last, input logic [31:0] d);
      in_mosi.tvalid = v;
      in_mosi.tid    = id;
      in_mosi.tlast  = last;
      in_mosi.tdata  = d;
   endtask

   task automatic set_rdy(input bit r);
      for (int j = 0; j < CH; j++) out_miso[j].tready = r;
   endtask

   // One clock: compare every output against the model, then advance model past the edge
   task automatic cycle(output bit acc);
      int ec;
      bit etr, hs, n_hold, n_drop;
      int n_lock;
      axis_mosi_t [CH-1:0] ev;
      logic [CH-1:0] el;
      #2;
      ec = -1;
      etr = 0;
      if (!rst) begin
         if (m_lock >= 0) begin
            if (!m_hold) ec = m_lock;
         end else if (in_mosi.tvalid) begin
            if (in_mosi.tid == ROUTING_HEADER) ec = route(tx, ty, vs, busy);
            else etr = 1;
         end
      end
      if (ec >= 0) etr = out_miso[ec].tready;
      ev = '0;
      if (ec >= 0) ev[ec] = in_mosi;
      el = '0;
      if (m_lock >= 0) el[m_lock] = 1'b1;
      total++;
      if (out_mosi !== ev) begin
         bad++;
         $display("FAIL out_mosi: got %h want %h", out_mosi, ev);
      end
      chk("tready", in_miso.tready, etr);
      chk("chan_lock", lock, el);
      chk("drop", drop, m_drop);
      acc = in_mosi.tvalid && in_miso.tready;
      hs  = (ec >= 0) && in_mosi.tvalid && etr;
      n_lock = m_lock;
      n_hold = m_hold;
      n_drop = 0;
      if (rst) begin
         n_lock = -1;
         n_hold = 0;
      end else begin
         n_drop = (m_lock < 0) && in_mosi.tvalid && (in_mosi.tid != ROUTING_HEADER);
         if (m_lock < 0) begin
            if (hs) begin
               n_lock = ec;
               n_hold = in_mosi.tlast;
            end
         end else if (m_hold || (hs && in_mosi.tlast)) begin
            n_lock = -1;
            n_hold = 0;
         end
      end
      @(posedge clk);
      #1;
      m_lock = n_lock;
      m_hold = n_hold;
      m_drop = n_drop;
   endtask

   typedef struct {
      int x;
      int y;
      int vsel;
      logic [CH-1:0] b;
      int e_fix;
      int e_ad;
   } vec_t;

   vec_t tbl[10];

   initial begin
      bit acc;
      int k, np, obs;
      bit tog;
      bit have, stray;
      int p_len, p_pos, p_x, p_y, p_v;

      tbl[0] = '{1, 1, 0, 15'h0000,  0,  0};
      tbl[1] = '{1, 0, 0, 15'h0000,  3,  3};
      tbl[2] = '{3, 1, 1, 15'h0040,  7,  7};
      tbl[3] = '{3, 1, 1, 15'h00C0, -1,  8};
      tbl[4] = '{0, 1, 3, 15'h0000, 12, 12};
      tbl[5] = '{2, 2, 2, 15'h0000, 11,  9};
      tbl[6] = '{0, 3, 1, 15'h0400, -1,  9};
      tbl[7] = '{3, 0, 2, 15'h0038, -1, -1};
      tbl[8] = '{2, 1, 0, 15'h0040, -1,  7};
      tbl[9] = '{1, 3, 2, 15'h0001, 11,  9};

      rst = 1;
      tx = 0; ty = 0; vs = 0; busy = '0;
      set_rdy(1);
      drv(1, ROUTING_HEADER, 0, 32'h0);
      @(posedge clk);
      #1;
      // reset state with a header waiting
      #2;
      chk("rst_tready", in_miso.tready, 0);
      chk("rst_lock", lock, 0);
      cycle(acc);
      cycle(acc);
      rst = 0;

      // routing table, downstream not ready so nothing is accepted
      set_rdy(0);
      for (int i = 0; i < 10; i++) begin
         tx = 2'(tbl[i].x);
         ty = 2'(tbl[i].y);
         vs = 2'(tbl[i].vsel);
         busy = tbl[i].b;
         drv(1, ROUTING_HEADER, 0, 32'h1000 + i);
         #2;
         obs = -1;
         for (int c = 0; c < CH; c++) if (out_mosi[c].tvalid) obs = (obs == -1) ? c : -2;
`ifdef ADAPTIVE_VC_EN
         chk("tbl_ch", obs, tbl[i].e_ad);
`else
         chk("tbl_ch", obs, tbl[i].e_fix);
`endif
         chk("tbl_tready", in_miso.tready, 0);
         @(posedge clk);
         #1;
      end

      // 4-beat packet, toggling downstream ready, header-TID beat mid-packet
      tx = 3; ty = 1; vs = 1; busy = '0;
      k = 0;
      tog = 0;
      for (int c = 0; c < 30 && k < 4; c++) begin
         set_rdy(tog);
         tog = !tog;
         drv(1, (k == 0 || k == 2) ? ROUTING_HEADER : 4'h2, k == 3, 32'hB000 + k);
         if (k >= 1) begin tx = 0; ty = 3; end
         cycle(acc);
         if (acc) k++;
      end
      chk("pkt_beats", k, 4);
      chk("lock_clear", lock, 0);
      // back-to-back single-beat packet
      tx = 1; ty = 0; vs = 0; busy = '0;
      set_rdy(1);
      drv(1, ROUTING_HEADER, 1, 32'hC0DE);
      cycle(acc);
      chk("b2b_accept", acc, 1);
      chk("single_lock", lock, 64'(1) << route(1, 0, 0, '0));
      drv(0, 4'h0, 0, 32'h0);
      cycle(acc);
      chk("single_release", lock, 0);
      cycle(acc);

      // stray beat while idle
      drv(1, 4'h3, 0, 32'h5555);
      #2;
      chk("stray_tready", in_miso.tready, 1);
      cycle(acc);
      drv(0, 4'h0, 0, 32'h0);
      chk("stray_drop", drop, 1);
      cycle(acc);

      // reset on beat 2 of 4
      tx = 1; ty = 1; vs = 0; busy = '0;
      drv(1, ROUTING_HEADER, 0, 32'hD0);
      cycle(acc);
      drv(1, 4'h2, 0, 32'hD1);
      cycle(acc);
      rst = 1;
      drv(1, 4'h2, 0, 32'hD2);
      cycle(acc);
      rst = 0;
      chk("rst_mid_lock", lock, 0);
      np = 0;
      drv(1, 4'h2, 0, 32'hD3);
      cycle(acc);
      np += int'(drop);
      drv(1, 4'h2, 1, 32'hD4);
      cycle(acc);
      np += int'(drop);
      drv(0, 4'h0, 0, 32'h0);
      cycle(acc);
      np += int'(drop);
      chk("rst_drops", np, 2);

      // header stalls on busy channel(s), accepted once channel 7 frees
      tx = 3; ty = 1; vs = 1; busy = 15'h01C0;
      drv(1, ROUTING_HEADER, 0, 32'hE0);
      for (int c = 0; c < 3; c++) begin
         cycle(acc);
         chk("stall", acc, 0);
      end
      busy = 15'h0140;
      cycle(acc);
      chk("unstall", acc, 1);
      chk("lock7", lock, 64'h80);
      drv(1, 4'h2, 1, 32'hE1);
      cycle(acc);
      drv(0, 4'h0, 0, 32'h0);
      cycle(acc);
      cycle(acc);

      // randomized traffic against the model
      have = 0;
      stray = 0;
      p_len = 0; p_pos = 0; p_x = 0; p_y = 0; p_v = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!have && $urandom_range(0, 3) != 0) begin
            have  = 1;
            stray = ($urandom_range(0, 9) == 0);
            p_len = stray ? 1 : $urandom_range(1, 4);
            p_pos = 0;
            p_x   = $urandom_range(0, 3);
            p_y   = $urandom_range(0, 3);
            p_v   = $urandom_range(0, 3);
         end
         if (have) begin
            logic [3:0] id;
            id = 4'($urandom_range(0, 14));
            if (id >= ROUTING_HEADER) id = id + 4'd1;
            if (p_pos == 0 && !stray) id = ROUTING_HEADER;
            else if (!stray && $urandom_range(0, 7) == 0) id = ROUTING_HEADER;
            drv(1, id, p_pos == p_len - 1, $urandom);
         end else begin
            drv(0, 4'($urandom_range(0, 15)), 0, $urandom);
         end
         tx = 2'(p_x);
         ty = 2'(p_y);
         vs = 2'(p_v);
         for (int j = 0; j < CH; j++) begin
            out_miso[j].tready = ($urandom_range(0, 2) != 0);
            busy[j] = ($urandom_range(0, 3) == 0);
         end
         rst = ($urandom_range(0, 149) == 0);
         cycle(acc);
         if (acc) begin
            p_pos++;
            if (p_pos == p_len) have = 0;
         end
      end
      rst = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
